// File: rtl/modn_updown_counter_if.sv
// Bus bundle for modn_updown_counter: control/load inputs and count/status outputs.
// Latency: none, signal bundle only.
// Backpressure: none; the counter accepts a step or load every cycle.
//
// Signals:
//   en, up_dn, load, data   : driven by the controlling logic (master)
//   count, tc, wrapped,
//   load_err                : driven by the counter (slave)
interface modn_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrapped;
  logic             load_err;

  modport master (
    output en, up_dn, load, data,
    input  count, tc, wrapped, load_err
  );

  modport slave (
    input  en, up_dn, load, data,
    output count, tc, wrapped, load_err
  );
endinterface

// File: rtl/modn_updown_counter.sv
// Modulo-MODULUS up/down counter with load, enable, wrap/saturate mode and cascade tc.
// Latency: count/wrapped/load_err update one edge after load/en is sampled; tc is combinational.
// Backpressure: none; one step or load per cycle, priority rst > load > en.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (count=0, pulses cleared)
//   bus.en     : count enable, bus.up_dn : 1 up / 0 down
//   bus.load   : parallel load of bus.data (out-of-range values clamp to MODULUS-1)
//   bus.count  : registered count, bus.tc : terminal count for cascading
//   bus.wrapped / bus.load_err : one-cycle registered pulses
module modn_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 12,
  parameter int SATURATE = 0
) (
  input logic                   clk,
  input logic                   rst,
  modn_updown_counter_if.slave  bus
);

  // Configuration guard: the range must have at least two states and fit in WIDTH bits.
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("modn_updown_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the range compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q;
  logic             wrapped_q;
  logic             load_err_q;
  logic             at_max;
  logic             at_min;
  logic             in_range;

  assign at_max   = (count_q == MAX_CNT);
  assign at_min   = (count_q == '0);
  assign in_range = ({1'b0, bus.data} < MOD_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else if (bus.load) begin
      count_q    <= in_range ? bus.data : MAX_CNT;
      load_err_q <= ~in_range;
      wrapped_q  <= 1'b0;
    end else if (bus.en) begin
      load_err_q <= 1'b0;
      if (bus.up_dn) begin
        if (!at_max) begin
          count_q   <= count_q + WIDTH'(1);
          wrapped_q <= 1'b0;
        end else if (SATURATE != 0) begin
          wrapped_q <= 1'b0;
        end else begin
          // Explicit wrap rather than relying on overflow, so wrapped fires for any modulus.
          count_q   <= '0;
          wrapped_q <= 1'b1;
        end
      end else begin
        if (!at_min) begin
          count_q   <= count_q - WIDTH'(1);
          wrapped_q <= 1'b0;
        end else if (SATURATE != 0) begin
          wrapped_q <= 1'b0;
        end else begin
          count_q   <= MAX_CNT;
          wrapped_q <= 1'b1;
        end
      end
    end else begin
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrapped  = wrapped_q;
  assign bus.load_err = load_err_q;

  // Unregistered so a cascaded stage steps on the same edge as this stage's wrap.
  // Still asserted in saturate mode so downstream logic sees the end of range.
  assign bus.tc = bus.en & ~rst & ~bus.load &
                  ((bus.up_dn & at_max) | (~bus.up_dn & at_min));

endmodule

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench: wrap, saturate, full-range and cascaded counter instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_modn_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] data;
  logic       casc_run;

  int vectors = 0;
  int miscompares = 0;

  // instance index: 0 wrap mod12, 1 saturate mod12, 2 wrap mod16, 3 cascade low, 4 cascade high
  int m_mod[5] = '{12, 12, 16, 12, 12};
  bit m_sat[5] = '{0, 1, 0, 0, 0};
  int m_cnt[5];
  bit m_wr[5];
  bit m_le[5];
  bit m_ok[5];

  bit pr[5], pl[5], pe[5], pu[5];
  int pd[5];
  bit cr, cl, ce, cu;
  int cd;

  modn_updown_counter_if #(.WIDTH(4)) a_if ();
  modn_updown_counter_if #(.WIDTH(4)) s_if ();
  modn_updown_counter_if #(.WIDTH(4)) f_if ();
  modn_updown_counter_if #(.WIDTH(4)) lo_if ();
  modn_updown_counter_if #(.WIDTH(4)) hi_if ();

  assign a_if.en = en;  assign a_if.up_dn = up_dn;  assign a_if.load = load;  assign a_if.data = data;
  assign s_if.en = en;  assign s_if.up_dn = up_dn;  assign s_if.load = load;  assign s_if.data = data;
  assign f_if.en = en;  assign f_if.up_dn = up_dn;  assign f_if.load = load;  assign f_if.data = data;
  assign lo_if.en = casc_run;  assign lo_if.up_dn = 1'b1;  assign lo_if.load = 1'b0;  assign lo_if.data = 4'd0;
  assign hi_if.en = lo_if.tc;  assign hi_if.up_dn = 1'b1;  assign hi_if.load = 1'b0;  assign hi_if.data = 4'd0;

  modn_updown_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(0)) u_wrap (.clk(clk), .rst(rst), .bus(a_if));
  modn_updown_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(1)) u_sat  (.clk(clk), .rst(rst), .bus(s_if));
  modn_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_full (.clk(clk), .rst(rst), .bus(f_if));
  modn_updown_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(0)) u_lo   (.clk(clk), .rst(rst), .bus(lo_if));
  modn_updown_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(0)) u_hi   (.clk(clk), .rst(rst), .bus(hi_if));

  logic [3:0] d_cnt[5];
  logic       d_tc[5], d_wr[5], d_le[5];
  assign d_cnt[0] = a_if.count;  assign d_tc[0] = a_if.tc;  assign d_wr[0] = a_if.wrapped;  assign d_le[0] = a_if.load_err;
  assign d_cnt[1] = s_if.count;  assign d_tc[1] = s_if.tc;  assign d_wr[1] = s_if.wrapped;  assign d_le[1] = s_if.load_err;
  assign d_cnt[2] = f_if.count;  assign d_tc[2] = f_if.tc;  assign d_wr[2] = f_if.wrapped;  assign d_le[2] = f_if.load_err;
  assign d_cnt[3] = lo_if.count; assign d_tc[3] = lo_if.tc; assign d_wr[3] = lo_if.wrapped; assign d_le[3] = lo_if.load_err;
  assign d_cnt[4] = hi_if.count; assign d_tc[4] = hi_if.tc; assign d_wr[4] = hi_if.wrapped; assign d_le[4] = hi_if.load_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Terminal count from the range rule: last value going up, first value going down.
  function automatic bit mtc(int c, int m, bit r, bit l, bit e, bit u);
    return e && !r && !l && ((u && c == m - 1) || (!u && c == 0));
  endfunction

  task automatic get_in(input int i, output bit r, output bit l, output bit e, output bit u, output int d);
    r = rst;
    if (i < 3) begin
      l = load; e = en; u = up_dn; d = int'(data);
    end else if (i == 3) begin
      l = 1'b0; e = casc_run; u = 1'b1; d = 0;
    end else begin
      l = 1'b0; u = 1'b1; d = 0;
      e = mtc(m_cnt[3], m_mod[3], rst, 1'b0, casc_run, 1'b1);
    end
  endtask

  // Reference model: integer range arithmetic, all inputs captured before any state update.
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) get_in(i, pr[i], pl[i], pe[i], pu[i], pd[i]);
    for (int i = 0; i < 5; i++) begin
      int n;
      if (pr[i]) begin
        m_cnt[i] = 0; m_wr[i] = 0; m_le[i] = 0; m_ok[i] = 1;
      end else if (pl[i]) begin
        m_le[i]  = (pd[i] >= m_mod[i]);
        m_cnt[i] = m_le[i] ? m_mod[i] - 1 : pd[i];
        m_wr[i]  = 0;
      end else if (pe[i]) begin
        m_le[i] = 0;
        n = pu[i] ? m_cnt[i] + 1 : m_cnt[i] - 1;
        if (n < 0 || n >= m_mod[i]) begin
          m_wr[i] = !m_sat[i];
          if (!m_sat[i]) m_cnt[i] = (n + m_mod[i]) % m_mod[i];
        end else begin
          m_cnt[i] = n;
          m_wr[i]  = 0;
        end
      end else begin
        m_wr[i] = 0; m_le[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (m_ok[i]) begin
        get_in(i, cr, cl, ce, cu, cd);
        check($sformatf("count[%0d]", i),    32'(d_cnt[i]), 32'(m_cnt[i]));
        check($sformatf("wrapped[%0d]", i),  32'(d_wr[i]),  32'(m_wr[i]));
        check($sformatf("load_err[%0d]", i), 32'(d_le[i]),  32'(m_le[i]));
        check($sformatf("tc[%0d]", i),       32'(d_tc[i]),  32'(mtc(m_cnt[i], m_mod[i], cr, cl, ce, cu)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sat_exp[5] = '{10, 11, 11, 11, 11};

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; data = 4'd0; casc_run = 1'b0;
    tick();
    rst = 1'b0;
    check("reset_count", 32'(a_if.count), 0);
    check("reset_wrapped", 32'(a_if.wrapped), 0);
    check("reset_load_err", 32'(a_if.load_err), 0);

    // Count up through the wrap.
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check("up_run_count", 32'(a_if.count), 32'(k % 12));
      check("up_run_wrapped", 32'(a_if.wrapped), 32'(k == 12));
      if (k == 11) check("tc_at_11", 32'(a_if.tc), 1);
      if (k == 12) check("tc_after_wrap", 32'(a_if.tc), 0);
    end

    // Load wins over enable, then count down through the wrap.
    load = 1'b1; data = 4'd6;
    tick();
    load = 1'b0;
    check("load6_count", 32'(a_if.count), 6);
    up_dn = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("down_run_count", 32'(a_if.count), 32'((6 - k + 12) % 12));
      if (k == 6) check("tc_down_at_0", 32'(a_if.tc), 1);
      if (k == 7) check("down_wrapped", 32'(a_if.wrapped), 1);
    end

    // Out-of-range load clamps and flags for one cycle.
    en = 1'b0; load = 1'b1; data = 4'd14;
    tick();
    check("load14_count", 32'(a_if.count), 11);
    check("load14_err", 32'(a_if.load_err), 1);
    check("load14_full_count", 32'(f_if.count), 14);
    check("load14_full_err", 32'(f_if.load_err), 0);
    data = 4'd11;
    tick();
    check("load11_err", 32'(a_if.load_err), 0);
    check("load11_count", 32'(a_if.count), 11);

    // Saturate instance holds at both ends.
    data = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sat_up_count", 32'(s_if.count), 32'(sat_exp[k]));
      check("sat_up_wrapped", 32'(s_if.wrapped), 0);
    end
    check("sat_tc_at_11", 32'(s_if.tc), 1);
    up_dn = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check("sat_down_count", 32'(s_if.count), 32'((11 - k) > 0 ? (11 - k) : 0));
      check("sat_down_wrapped", 32'(s_if.wrapped), 0);
    end
    check("sat_tc_at_0", 32'(s_if.tc), 1);

    // Full-range modulus still reports the wrap.
    en = 1'b0; load = 1'b1; data = 4'd15;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    check("full_wrap_count", 32'(f_if.count), 0);
    check("full_wrap_flag", 32'(f_if.wrapped), 1);

    // tc gating by load and by reset.
    en = 1'b0; load = 1'b1; data = 4'd11;
    tick();
    en = 1'b1; up_dn = 1'b1; load = 1'b1; data = 4'd3;
    #1;
    check("tc_gated_load", 32'(a_if.tc), 0);
    load = 1'b0; rst = 1'b1;
    #1;
    check("tc_gated_rst", 32'(a_if.tc), 0);
    rst = 1'b0; load = 1'b1; data = 4'd7; en = 1'b0;
    tick();
    check("load7_count", 32'(a_if.count), 7);
    rst = 1'b1; load = 1'b1; data = 4'd3; en = 1'b1;
    #1;
    check("tc_rst_cycle", 32'(a_if.tc), 0);
    tick();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    check("rst_over_load", 32'(a_if.count), 0);

    // Random phase, compared every cycle by the model.
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 63) == 0);
      load  = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
      data  = 4'($urandom_range(0, 15));
      tick();
    end

    // Cascade: high stage advances once per low-stage wrap.
    rst = 1'b1; en = 1'b0; load = 1'b0;
    tick();
    rst = 1'b0; casc_run = 1'b1;
    for (int k = 1; k <= 144; k++) begin
      tick();
      if (k == 12) begin
        check("casc12_lo", 32'(lo_if.count), 0);
        check("casc12_hi", 32'(hi_if.count), 1);
      end
      if (k == 143) begin
        check("casc143_lo", 32'(lo_if.count), 11);
        check("casc143_hi", 32'(hi_if.count), 11);
        check("casc143_hi_tc", 32'(hi_if.tc), 1);
      end
      if (k == 144) begin
        check("casc144_lo", 32'(lo_if.count), 0);
        check("casc144_hi", 32'(hi_if.count), 0);
      end
    end
    casc_run = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
